// File: rtl/fetch_pkg.sv
// Shared constants and state type for the jr-aware fetch PC controller.
package fetch_pkg;
  localparam int          PC_W     = 10;
  localparam logic [9:0]  RESET_PC = 10'd0;
  localparam int          FETCH_W  = 2;

  typedef enum logic {
    RUN     = 1'b0,
    WAIT_JR = 1'b1
  } fetch_state_e;
endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC / next-state priority select for the fetch controller.
module pc_next_sel
  import fetch_pkg::*;
(
  input  fetch_state_e    state,
  input  logic [PC_W-1:0] pc,
  input  logic            stall,
  input  logic            flush,
  input  logic [PC_W-1:0] flush_target,
  input  logic            dec_jump,
  input  logic [PC_W-1:0] dec_jump_target,
  input  logic            jr_detect,
  input  logic            jr_src_ready,
  input  logic [PC_W-1:0] jr_src_val,
  input  logic            jr_out,
  input  logic [PC_W-1:0] jr_addr,
  output logic [PC_W-1:0] pc_nxt,
  output fetch_state_e    state_nxt
);

  always_comb begin
    pc_nxt    = pc;
    state_nxt = state;
    if (flush) begin
      pc_nxt    = flush_target;
      state_nxt = RUN;
    end else if (state == WAIT_JR) begin
      // a resolve pulse seen while running is stale and never reaches here
      if (jr_out) begin
        pc_nxt    = jr_addr;
        state_nxt = RUN;
      end
    end else if (stall) begin
      pc_nxt = pc;
    end else if (jr_detect) begin
      if (jr_src_ready) pc_nxt = jr_src_val;
      else              state_nxt = WAIT_JR;
    end else if (dec_jump) begin
      pc_nxt = dec_jump_target;
    end else begin
      pc_nxt = pc + PC_W'(FETCH_W);
    end
  end

endmodule

// File: rtl/jr_fetch_ctrl.sv
// 2-wide fetch PC controller that freezes on unresolved jr until the RS broadcasts.
// Optional macro JR_PERF_EN adds a saturating WAIT_JR cycle counter output.
//
// state   | meaning
// RUN     | fetching; pc advances, jumps or redirects each cycle
// WAIT_JR | jr target unknown; fetch frozen until jr_out or flush
module jr_fetch_ctrl
  import fetch_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic [PC_W-1:0] flush_target,
  input  logic            dec_jump,
  input  logic [PC_W-1:0] dec_jump_target,
  input  logic            jr_detect,
  input  logic            jr_src_ready,
  input  logic [PC_W-1:0] jr_src_val,
  input  logic            jr_out,
  input  logic [PC_W-1:0] jr_addr,
  output logic [PC_W-1:0] pc_out,
  output logic [1:0]      fetch_valid,
  output logic            jr_wait
`ifdef JR_PERF_EN
  ,
  output logic [15:0]     jr_wait_cycles
`endif
);

  fetch_state_e    state, state_nxt;
  logic [PC_W-1:0] pc, pc_nxt;

  pc_next_sel u_sel (
    .state           (state),
    .pc              (pc),
    .stall           (stall),
    .flush           (flush),
    .flush_target    (flush_target),
    .dec_jump        (dec_jump),
    .dec_jump_target (dec_jump_target),
    .jr_detect       (jr_detect),
    .jr_src_ready    (jr_src_ready),
    .jr_src_val      (jr_src_val),
    .jr_out          (jr_out),
    .jr_addr         (jr_addr),
    .pc_nxt          (pc_nxt),
    .state_nxt       (state_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pc    <= RESET_PC;
      state <= RUN;
    end else begin
      pc    <= pc_nxt;
      state <= state_nxt;
    end
  end

  assign pc_out      = pc;
  assign fetch_valid = {2{state == RUN}};
  assign jr_wait     = (state == WAIT_JR);

`ifdef JR_PERF_EN
  always_ff @(posedge clk) begin
    if (rst)
      jr_wait_cycles <= 16'd0;
    else if (state == WAIT_JR && jr_wait_cycles != 16'hFFFF)
      jr_wait_cycles <= jr_wait_cycles + 16'd1;
  end
`endif

endmodule

// File: tb/tb_jr_fetch_ctrl.sv
// Self-checking bench for jr_fetch_ctrl: directed scenarios plus randomized run vs reference model.
module tb_jr_fetch_ctrl;
  logic       clk = 1'b0;
  logic       rst, stall, flush, dec_jump, jr_detect, jr_src_ready, jr_out;
  logic [9:0] flush_target, dec_jump_target, jr_src_val, jr_addr;
  logic [9:0] pc_out;
  logic [1:0] fetch_valid;
  logic       jr_wait;
`ifdef JR_PERF_EN
  logic [15:0] jr_wait_cycles;
`endif

  int checks = 0;
  int errors = 0;

  // reference model
  logic [9:0]  m_pc;
  bit          m_wait;
  logic [15:0] m_cnt;

  always #5 clk = ~clk;

  jr_fetch_ctrl dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .flush_target(flush_target),
    .dec_jump(dec_jump), .dec_jump_target(dec_jump_target), .jr_detect(jr_detect),
    .jr_src_ready(jr_src_ready), .jr_src_val(jr_src_val), .jr_out(jr_out), .jr_addr(jr_addr),
    .pc_out(pc_out), .fetch_valid(fetch_valid), .jr_wait(jr_wait)
`ifdef JR_PERF_EN
    , .jr_wait_cycles(jr_wait_cycles)
`endif
  );

  task automatic model_edge();
    if (rst) begin
      m_pc = 10'd0; m_wait = 0; m_cnt = 16'd0;
    end else begin
      if (m_wait && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      if (flush) begin
        m_pc = flush_target; m_wait = 0;
      end else if (m_wait) begin
        if (jr_out) begin m_pc = jr_addr; m_wait = 0; end
      end else if (stall) begin
      end else if (jr_detect) begin
        if (jr_src_ready) m_pc = jr_src_val;
        else              m_wait = 1;
      end else if (dec_jump) begin
        m_pc = dec_jump_target;
      end else begin
        m_pc = 10'((int'(m_pc) + 2) % 1024);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    rst = 0; stall = 0; flush = 0; dec_jump = 0; jr_detect = 0; jr_src_ready = 0; jr_out = 0;
    flush_target = '0; dec_jump_target = '0; jr_src_val = '0; jr_addr = '0;
  endtask

  task automatic do_reset();
    rst = 1; tick(); rst = 0;
  endtask

  task automatic test_reset();
    logic [9:0] exp_pc;
    idle_inputs();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      exp_pc = 10'(2 * i);
      checks++;
      if (pc_out !== exp_pc || fetch_valid !== 2'b11 || jr_wait !== 1'b0) begin
        errors++;
        $display("FAIL reset_seq[%0d]: pc=%h valid=%b wait=%b, required pc=%h valid=11 wait=0",
                 i, pc_out, fetch_valid, jr_wait, exp_pc);
      end
      tick();
    end
  endtask

  task automatic test_jr_wait();
    idle_inputs();
    do_reset();
    flush = 1; flush_target = 10'd8; tick(); flush = 0;
    checks++;
    if (pc_out !== 10'd8) begin
      errors++; $display("FAIL flush_to_8: pc=%h required 008", pc_out);
    end
    jr_detect = 1; jr_src_ready = 0; tick(); jr_detect = 0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (pc_out !== 10'd8 || fetch_valid !== 2'b00 || jr_wait !== 1'b1) begin
        errors++;
        $display("FAIL jr_wait_hold[%0d]: pc=%h valid=%b wait=%b, required pc=008 valid=00 wait=1",
                 i, pc_out, fetch_valid, jr_wait);
      end
      if (i == 2) begin jr_out = 1; jr_addr = 10'h155; end
      tick();
    end
    jr_out = 0;
    checks++;
    if (pc_out !== 10'h155 || fetch_valid !== 2'b11 || jr_wait !== 1'b0) begin
      errors++;
      $display("FAIL jr_resolve: pc=%h valid=%b wait=%b, required pc=155 valid=11 wait=0",
               pc_out, fetch_valid, jr_wait);
    end
  endtask

  task automatic test_fast_path_wrap();
    idle_inputs();
    jr_detect = 1; jr_src_ready = 1; jr_src_val = 10'h3FF; tick();
    idle_inputs();
    checks++;
    if (pc_out !== 10'h3FF || jr_wait !== 1'b0 || fetch_valid !== 2'b11) begin
      errors++; $display("FAIL fast_path: pc=%h wait=%b valid=%b, required pc=3ff wait=0 valid=11",
                         pc_out, jr_wait, fetch_valid);
    end
    tick();
    checks++;
    if (pc_out !== 10'h001 || jr_wait !== 1'b0) begin
      errors++; $display("FAIL wrap: pc=%h wait=%b, required pc=001 wait=0", pc_out, jr_wait);
    end
  endtask

  task automatic test_flush_vs_jr_out();
    idle_inputs();
    jr_detect = 1; tick(); jr_detect = 0;
    flush = 1; flush_target = 10'h40; jr_out = 1; jr_addr = 10'h80; tick();
    flush = 0; jr_out = 0;
    checks++;
    if (pc_out !== 10'h40 || jr_wait !== 1'b0) begin
      errors++; $display("FAIL flush_wins: pc=%h wait=%b, required pc=040 wait=0", pc_out, jr_wait);
    end
    jr_out = 1; jr_addr = 10'h80; tick(); jr_out = 0;
    checks++;
    if (pc_out !== 10'h42) begin
      errors++; $display("FAIL stale_jr_out: pc=%h required 042", pc_out);
    end
  endtask

  task automatic test_stall();
    logic [9:0] held;
    idle_inputs();
    held = pc_out;
    stall = 1; dec_jump = 1; dec_jump_target = 10'h20;
    tick(); tick();
    checks++;
    if (pc_out !== held) begin
      errors++; $display("FAIL stall_run: pc=%h required %h", pc_out, held);
    end
    stall = 0; dec_jump = 0;
    jr_detect = 1; tick(); jr_detect = 0;
    stall = 1; jr_out = 1; jr_addr = 10'h2A5; tick(); jr_out = 0; stall = 0;
    checks++;
    if (pc_out !== 10'h2A5 || jr_wait !== 1'b0) begin
      errors++; $display("FAIL stall_wait_redirect: pc=%h wait=%b, required pc=2a5 wait=0",
                         pc_out, jr_wait);
    end
    jr_detect = 1; tick(); jr_detect = 0;
    rst = 1; jr_out = 1; jr_addr = 10'h111; flush = 1; flush_target = 10'h222; tick();
    idle_inputs();
    checks++;
    if (pc_out !== 10'd0 || jr_wait !== 1'b0 || fetch_valid !== 2'b11) begin
      errors++; $display("FAIL reset_mid_wait: pc=%h wait=%b valid=%b, required pc=000 wait=0 valid=11",
                         pc_out, jr_wait, fetch_valid);
    end
  endtask

`ifdef JR_PERF_EN
  task automatic test_perf();
    idle_inputs();
    do_reset();
    jr_detect = 1; tick(); jr_detect = 0;
    tick(); tick(); jr_out = 1; tick(); jr_out = 0;
    jr_detect = 1; tick(); jr_detect = 0;
    for (int i = 0; i < 4; i++) tick();
    jr_out = 1; tick(); jr_out = 0;
    checks++;
    if (jr_wait_cycles !== 16'd8) begin
      errors++; $display("FAIL perf_count: got %0d required 8", jr_wait_cycles);
    end
    jr_detect = 1; tick(); jr_detect = 0;
    for (int i = 0; i < 65545; i++) tick();
    checks++;
    if (jr_wait_cycles !== 16'hFFFF) begin
      errors++; $display("FAIL perf_saturate: got %h required ffff", jr_wait_cycles);
    end
    do_reset();
    checks++;
    if (jr_wait_cycles !== 16'd0) begin
      errors++; $display("FAIL perf_clear: got %h required 0000", jr_wait_cycles);
    end
  endtask
`endif

  task automatic test_random();
    idle_inputs();
    do_reset();
    for (int n = 0; n < 500; n++) begin
      rst             = ($urandom_range(0, 63) == 0);
      stall           = ($urandom_range(0, 4) == 0);
      flush           = ($urandom_range(0, 11) == 0);
      dec_jump        = ($urandom_range(0, 3) == 0);
      jr_detect       = ($urandom_range(0, 5) == 0);
      jr_src_ready    = $urandom_range(0, 1) == 1;
      jr_out          = ($urandom_range(0, 3) == 0);
      flush_target    = 10'($urandom);
      dec_jump_target = 10'($urandom);
      jr_src_val      = 10'($urandom);
      jr_addr         = 10'($urandom);
      tick();
      checks++;
      if (pc_out !== m_pc || jr_wait !== m_wait || fetch_valid !== {2{!m_wait}}) begin
        errors++;
        $display("FAIL random[%0d]: pc=%h wait=%b valid=%b, required pc=%h wait=%b valid=%b",
                 n, pc_out, jr_wait, fetch_valid, m_pc, m_wait, {2{!m_wait}});
      end
`ifdef JR_PERF_EN
      checks++;
      if (jr_wait_cycles !== m_cnt) begin
        errors++; $display("FAIL random_cnt[%0d]: got %0d required %0d", n, jr_wait_cycles, m_cnt);
      end
`endif
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    m_pc = '0; m_wait = 0; m_cnt = '0;
    test_reset();
    test_jr_wait();
    test_fast_path_wrap();
    test_flush_vs_jr_out();
    test_stall();
`ifdef JR_PERF_EN
    test_perf();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
